// File: rtl/ctrl_types_pkg.sv
// Control-path types for the MEM-stage access unit: FSM states and store-width codes.
// Pure type definitions; no latency, no flow control.
// Store-width codes follow the RISC-V funct3 field of sb/sh/sw.
package ctrl_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mau_state_t;

    localparam logic [2:0] ST_BYTE = 3'b000;
    localparam logic [2:0] ST_HALF = 3'b001;
    localparam logic [2:0] ST_WORD = 3'b010;

    // Byte enables for a store; unknown widths fall back to a full word.
    function automatic logic [3:0] store_mbe(input logic [2:0] funct3, input logic [1:0] a);
        case (funct3)
            ST_BYTE: store_mbe = 4'b0001 << a;
            ST_HALF: store_mbe = a[1] ? 4'b1100 : 4'b0011;
            default: store_mbe = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dcachemux_pkg.sv
// Load-data mux select encodings shared by the MEM stage and the regfile writeback mux.
// Pure type definitions; no latency, no flow control.
// Consumers import dcachemux::* to decode lw/lh/lhu/lb/lbu.
package dcachemux;

    typedef enum logic [2:0] {
        LW  = 3'd0,
        LH  = 3'd1,
        LHU = 3'd2,
        LB  = 3'd3,
        LBU = 3'd4
    } dcachemux_sel_t;

endpackage

// File: rtl/mem_load_align.sv
// Load aligner: selects byte/half lane from a returned word and sign/zero-extends it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module mem_load_align
    import dcachemux::*;
(
    input  logic [31:0]    rdata,
    input  dcachemux_sel_t sel,
    input  logic [1:0]     addr_lo,
    output logic [31:0]    rdata_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (sel)
            LB:      rdata_o = {{24{byte_v[7]}}, byte_v};
            LBU:     rdata_o = {24'd0, byte_v};
            LH:      rdata_o = {{16{half_v[15]}}, half_v};
            LHU:     rdata_o = {16'd0, half_v};
            default: rdata_o = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit (optional MEM_MISALIGN_TRAP_EN adds misaligned_o trap path).
// Latency: request edge N, dcache request from N+1, result pulse one cycle after dcache_resp.
// Backpressure: stall_o holds upstream from request acceptance until the DONE cycle.
module mem_access_unit
    import ctrl_types::*;
    import dcachemux::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              dcache_read_i,
    input  logic              dcache_write_i,
    input  dcachemux_sel_t    rdata_sel_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              misaligned_o,
`endif
    output logic              dcache_read,
    output logic              dcache_write,
    output logic [ADDR_W-1:0] dcache_addr,
    output logic [DATA_W-1:0] dcache_wdata,
    output logic [3:0]        dcache_mbe,
    input  logic [DATA_W-1:0] dcache_rdata,
    input  logic              dcache_resp
);

    mau_state_t     state, state_n;
    logic           req;
    logic           rd_q, wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q, load_data;
    dcachemux_sel_t sel_q;
    logic [2:0]     funct3_q;
    logic           misalign;

    assign req = valid_i & (dcache_read_i | dcache_write_i);

`ifdef MEM_MISALIGN_TRAP_EN
    logic is_half, is_word, mis_q;

    always_comb begin
        if (dcache_read_i) begin
            is_half = (rdata_sel_i == LH) || (rdata_sel_i == LHU);
            is_word = (rdata_sel_i == LW);
        end else begin
            is_half = (funct3_i == ST_HALF);
            is_word = (funct3_i != ST_HALF) && (funct3_i != ST_BYTE);
        end
        misalign = (is_half & addr_i[0]) | (is_word & (|addr_i[1:0]));
    end

    always_ff @(posedge clk) begin
        if (rst)
            mis_q <= 1'b0;
        else if (state == IDLE && req)
            mis_q <= misalign;
    end

    assign misaligned_o = (state == DONE) & mis_q;
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req) state_n = misalign ? DONE : BUSY;
            BUSY:    if (dcache_resp) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    mem_load_align u_align (
        .rdata   (dcache_rdata),
        .sel     (sel_q),
        .addr_lo (addr_q[1:0]),
        .rdata_o (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            sel_q    <= LW;
            funct3_q <= ST_WORD;
            rdata_q  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && req) begin
                // A simultaneous read+write is resolved as a plain load.
                rd_q     <= dcache_read_i;
                wr_q     <= dcache_write_i & ~dcache_read_i;
                addr_q   <= addr_i;
                wdata_q  <= wdata_i;
                sel_q    <= rdata_sel_i;
                funct3_q <= funct3_i;
                rdata_q  <= '0;
            end
            if (state == BUSY && dcache_resp && rd_q)
                rdata_q <= load_data;
        end
    end

    always_comb begin
        stall_o       = (state == BUSY) || (state == IDLE && req);
        rdata_valid_o = (state == DONE);
        rdata_o       = (state == DONE) ? rdata_q : '0;
        dcache_read   = (state == BUSY) & rd_q;
        dcache_write  = (state == BUSY) & wr_q;
        dcache_addr   = '0;
        dcache_wdata  = '0;
        dcache_mbe    = 4'b0000;
        if (state == BUSY) begin
            dcache_addr = {addr_q[ADDR_W-1:2], 2'b00};
            if (wr_q) begin
                dcache_mbe = store_mbe(funct3_q, addr_q[1:0]);
                case (funct3_q)
                    ST_BYTE: dcache_wdata = {4{wdata_q[7:0]}};
                    ST_HALF: dcache_wdata = {2{wdata_q[15:0]}};
                    default: dcache_wdata = wdata_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed-vector bench for mem_access_unit (MEM_MISALIGN_TRAP_EN vectors included when defined).
module tb_mem_access_unit;
    import dcachemux::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           valid_i, dcache_read_i, dcache_write_i;
    dcachemux_sel_t rdata_sel_i;
    logic [2:0]     funct3_i;
    logic [31:0]    addr_i, wdata_i;
    logic           stall_o, rdata_valid_o;
    logic [31:0]    rdata_o;
    logic           dcache_read, dcache_write, dcache_resp;
    logic [31:0]    dcache_addr, dcache_wdata, dcache_rdata;
    logic [3:0]     dcache_mbe;
`ifdef MEM_MISALIGN_TRAP_EN
    logic           misaligned_o;
`endif

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i        (valid_i),
        .dcache_read_i  (dcache_read_i),
        .dcache_write_i (dcache_write_i),
        .rdata_sel_i    (rdata_sel_i),
        .funct3_i       (funct3_i),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .stall_o        (stall_o),
        .rdata_o        (rdata_o),
        .rdata_valid_o  (rdata_valid_o),
`ifdef MEM_MISALIGN_TRAP_EN
        .misaligned_o   (misaligned_o),
`endif
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_addr    (dcache_addr),
        .dcache_wdata   (dcache_wdata),
        .dcache_mbe     (dcache_mbe),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request: IDLE cycle, k BUSY cycles (resp in the k-th), DONE, then 3 idle cycles.
    task automatic run_req(input logic rd, input logic wr, input dcachemux_sel_t sel,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input int k, input logic [31:0] rsp,
                           output logic [31:0] rdata, output int stalls, output int pulses,
                           output logic [31:0] sa, output logic [31:0] swd, output logic [3:0] smbe,
                           output int rd_cyc, output int wr_cyc);
        stalls = 0; pulses = 0; rd_cyc = 0; wr_cyc = 0;
        sa = '0; swd = '0; smbe = '0; rdata = '0;
        @(posedge clk); #1;
        valid_i = 1'b1; dcache_read_i = rd; dcache_write_i = wr;
        rdata_sel_i = sel; funct3_i = f3; addr_i = a; wdata_i = wd;
        #1;
        if (stall_o) stalls++;
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            valid_i = 1'b0; addr_i = 32'hDEAD_BEEF; wdata_i = 32'h5555_5555;
            dcache_resp = (i == k - 1);
            dcache_rdata = (i == k - 1) ? rsp : 32'h0;
            #1;
            if (stall_o) stalls++;
            if (rdata_valid_o) pulses++;
            if (dcache_read) rd_cyc++;
            if (dcache_write) wr_cyc++;
            if (i == 0) begin sa = dcache_addr; swd = dcache_wdata; smbe = dcache_mbe; end
        end
        @(posedge clk); #1;
        dcache_resp = 1'b0; dcache_rdata = 32'h0;
        #1;
        if (stall_o) stalls++;
        if (rdata_valid_o) pulses++;
        rdata = rdata_o;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            if (stall_o) stalls++;
            if (rdata_valid_o) pulses++;
            if (dcache_read) rd_cyc++;
        end
    endtask

    logic [31:0] rd_v, sa, swd;
    logic [3:0]  smbe;
    int          st, pu, rc, wc;

    initial begin
        rst = 1'b1; valid_i = 1'b0; dcache_read_i = 1'b0; dcache_write_i = 1'b0;
        rdata_sel_i = LW; funct3_i = 3'b010; addr_i = '0; wdata_i = '0;
        dcache_rdata = '0; dcache_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_vec("rst_stall", {31'd0, stall_o}, 32'd0);
        check_vec("rst_rvalid", {31'd0, rdata_valid_o}, 32'd0);
        check_vec("rst_rd", {31'd0, dcache_read}, 32'd0);
        check_vec("rst_wr", {31'd0, dcache_write}, 32'd0);
        check_vec("rst_mbe", {28'd0, dcache_mbe}, 32'd0);

        run_req(1, 0, LB, 3'b000, 32'h0000_1003, 32'h0, 1, 32'h80FF_1234, rd_v, st, pu, sa, swd, smbe, rc, wc);
        check_vec("lb_data", rd_v, 32'hFFFF_FF80);
        check_vec("lb_addr", sa, 32'h0000_1000);
        check_vec("lb_pulses", pu, 1);
        check_vec("lb_stalls", st, 2);
        check_vec("lb_rdcyc", rc, 1);
        check_vec("lb_wrcyc", wc, 0);

        run_req(1, 0, LHU, 3'b000, 32'h0000_1002, 32'h0, 3, 32'h8001_7FFF, rd_v, st, pu, sa, swd, smbe, rc, wc);
        check_vec("lhu_data", rd_v, 32'h0000_8001);
        check_vec("lhu_rdcyc", rc, 3);

        run_req(0, 1, LW, 3'b000, 32'h0000_2002, 32'h1234_56AB, 2, 32'h0, rd_v, st, pu, sa, swd, smbe, rc, wc);
        check_vec("sb_mbe", {28'd0, smbe}, 32'h4);
        check_vec("sb_wdata", swd, 32'hABAB_ABAB);
        check_vec("sb_addr", sa, 32'h0000_2000);
        check_vec("sb_wrcyc", wc, 2);
        check_vec("sb_rdcyc", rc, 0);
        check_vec("sb_pulses", pu, 1);
        check_vec("sb_rdata", rd_v, 32'h0);

        run_req(1, 0, LW, 3'b010, 32'h0000_3004, 32'h0, 5, 32'hCAFE_F00D, rd_v, st, pu, sa, swd, smbe, rc, wc);
        check_vec("lw5_stalls", st, 6);
        check_vec("lw5_pulses", pu, 1);
        check_vec("lw5_data", rd_v, 32'hCAFE_F00D);
        check_vec("lw5_addr", sa, 32'h0000_3004);

        run_req(0, 1, LW, 3'b001, 32'h0000_4006, 32'h0000_BEEF, 1, 32'h0, rd_v, st, pu, sa, swd, smbe, rc, wc);
        check_vec("sh_mbe", {28'd0, smbe}, 32'hC);
        check_vec("sh_wdata", swd, 32'hBEEF_BEEF);

        run_req(0, 1, LW, 3'b111, 32'h0000_5008, 32'h1122_3344, 1, 32'h0, rd_v, st, pu, sa, swd, smbe, rc, wc);
        check_vec("sx_mbe", {28'd0, smbe}, 32'hF);
        check_vec("sx_wdata", swd, 32'h1122_3344);

        run_req(1, 0, LH, 3'b000, 32'h0000_6000, 32'h0, 1, 32'h1234_8001, rd_v, st, pu, sa, swd, smbe, rc, wc);
        check_vec("lh_data", rd_v, 32'hFFFF_8001);
        run_req(1, 0, LB, 3'b000, 32'h0000_6001, 32'h0, 1, 32'h0000_7F00, rd_v, st, pu, sa, swd, smbe, rc, wc);
        check_vec("lb_pos", rd_v, 32'h0000_007F);
        run_req(1, 0, LBU, 3'b000, 32'h0000_6000, 32'h0, 1, 32'h0000_00FF, rd_v, st, pu, sa, swd, smbe, rc, wc);
        check_vec("lbu_data", rd_v, 32'h0000_00FF);

        run_req(1, 1, LW, 3'b010, 32'h0000_7000, 32'hFFFF_FFFF, 2, 32'h0BAD_F00D, rd_v, st, pu, sa, swd, smbe, rc, wc);
        check_vec("rw_rdcyc", rc, 2);
        check_vec("rw_wrcyc", wc, 0);
        check_vec("rw_data", rd_v, 32'h0BAD_F00D);

        // Reset while BUSY, then a stale response.
        @(posedge clk); #1;
        valid_i = 1'b1; dcache_read_i = 1'b1; dcache_write_i = 1'b0;
        rdata_sel_i = LW; addr_i = 32'h0000_8000;
        @(posedge clk); #1 valid_i = 1'b0;
        #1 check_vec("pre_rst_rd", {31'd0, dcache_read}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        #1;
        check_vec("midrst_rd", {31'd0, dcache_read}, 32'd0);
        check_vec("midrst_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1 dcache_resp = 1'b1; dcache_rdata = 32'h1234_5678;
        @(posedge clk); #1 dcache_resp = 1'b0;
        #1;
        check_vec("late_rvalid", {31'd0, rdata_valid_o}, 32'd0);
        check_vec("late_stall", {31'd0, stall_o}, 32'd0);
        check_vec("late_rd", {31'd0, dcache_read}, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
        @(posedge clk); #1;
        valid_i = 1'b1; dcache_read_i = 1'b1; dcache_write_i = 1'b0;
        rdata_sel_i = LW; addr_i = 32'h0000_9001;
        #1;
        check_vec("mis_stall", {31'd0, stall_o}, 32'd1);
        check_vec("mis_rd0", {31'd0, dcache_read}, 32'd0);
        @(posedge clk); #1 valid_i = 1'b0;
        #1;
        check_vec("mis_flag", {31'd0, misaligned_o}, 32'd1);
        check_vec("mis_rvalid", {31'd0, rdata_valid_o}, 32'd1);
        check_vec("mis_rdata", rdata_o, 32'd0);
        check_vec("mis_rd1", {31'd0, dcache_read}, 32'd0);
        @(posedge clk); #2;
        check_vec("mis_clear", {31'd0, misaligned_o}, 32'd0);
        check_vec("mis_rd2", {31'd0, dcache_read}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
